fir_decim_4x: RTL and testbench

//  4x decimating FIR filter with a single time-shared MAC. Pairs with the 4x

---
 rtl/fir_decim_4x.sv | 149 ++++++++++++++
 tb/tb_fir_decim_4x.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_4x.sv
// 4x decimating FIR filter: collects four samples into a delay line, then runs one
// time-shared MAC over all taps and emits a rounded, saturated 24-bit result.
module fir_decim_4x #(
  parameter int unsigned TAPS   = 16,
  parameter int unsigned COEF_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [23:0]             in_sample,
  output logic                    out_valid,
  output logic [23:0]             out_sample,
  output logic                    out_sat,
  output logic                    busy,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data
);

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned IDX_W  = $clog2(TAPS);
  localparam int unsigned FRAC_W = 15;
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'(64'sd8388607);
  localparam logic signed [ACC_W-1:0] OUT_MIN  = ACC_W'(-64'sd8388608);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'sd16384);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_MAC     = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t state;
  state_t state_n;
  logic   in_ready_n;
  logic   busy_n;

  logic [1:0]               phase;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];

  logic                     accept_c;
  logic                     coef_wr_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  rnd_c;
  logic signed [ACC_W-1:0]  shr_c;
  logic [DATA_W-1:0]        res_c;
  logic                     sat_c;

  assign accept_c  = in_valid && in_ready;
  // Coefficients only change while idle, so a running computation sees a stable set
  assign coef_wr_c = coef_we && (state == S_COLLECT) && (32'(coef_addr) < TAPS);
  assign prod_c    = PROD_W'(x[idx]) * PROD_W'(h[idx]);
  assign rnd_c     = acc + RND_HALF;
  assign shr_c     = rnd_c >>> FRAC_W;

  // Round-half-up result clipped to the 24-bit signed range
  always_comb begin
    res_c = shr_c[DATA_W-1:0];
    sat_c = 1'b0;
    if (shr_c > OUT_MAX) begin
      res_c = 24'h7FFFFF;
      sat_c = 1'b1;
    end else if (shr_c < OUT_MIN) begin
      res_c = 24'h800000;
      sat_c = 1'b1;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_n    = state;
    in_ready_n = 1'b0;
    busy_n     = 1'b0;
    case (state)
      S_COLLECT: if (accept_c && (phase == 2'd3)) state_n = S_MAC;
      S_MAC:     if (idx == IDX_W'(TAPS - 1)) state_n = S_OUT;
      S_OUT:     state_n = S_COLLECT;
      default:   state_n = S_COLLECT;
    endcase
    in_ready_n = (state_n == S_COLLECT);
    busy_n     = (state_n != S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_COLLECT;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= in_ready_n;
      busy     <= busy_n;
    end
  end

  // Delay line, coefficient bank, MAC and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= 2'd0;
      idx        <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_sat    <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        x[i] <= '0;
        h[i] <= (i < 4) ? COEF_W'(4096) : '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (accept_c) begin
        x[0]  <= in_sample;
        phase <= phase + 2'd1;
        for (int k = 1; k < int'(TAPS); k++) begin
          x[k] <= x[k-1];
        end
      end
      if (coef_wr_c) begin
        h[coef_addr] <= coef_data;
      end
      case (state)
        S_COLLECT: begin
          acc <= '0;
          idx <= '0;
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod_c);
          idx <= idx + IDX_W'(1);
        end
        S_OUT: begin
          out_valid  <= 1'b1;
          out_sample <= res_c;
          out_sat    <= sat_c;
        end
        default: begin
          acc <= '0;
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim_4x.sv
// Bench for fir_decim_4x: vector table plus hand sequences; every output is checked
// against a plain dot-product reference model through an expectation queue.
`timescale 1ns/1ps
module tb_fir_decim_4x;

  localparam int unsigned TAPS   = 16;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned AW     = $clog2(TAPS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [23:0]       in_sample = '0;
  logic              out_valid;
  logic [23:0]       out_sample;
  logic              out_sat;
  logic              busy;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;

  always #5 clk = ~clk;

  fir_decim_4x #(.TAPS(TAPS), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .out_valid(out_valid), .out_sample(out_sample),
    .out_sat(out_sat), .busy(busy), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data)
  );

  typedef struct {
    logic [23:0] sample;
    logic        chk;
    logic [23:0] exp_out;
    logic        exp_sat;
  } vec_t;

  typedef struct {
    logic [23:0] e_out;
    logic        e_sat;
    logic        has_c;
    logic [23:0] c_out;
    logic        c_sat;
  } exp_t;

  vec_t   vecs[$];
  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_out    = 0;
  longint mx [TAPS];
  longint mh [TAPS];
  int     mphase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(TAPS); i++) begin
      mx[i] = 0;
      mh[i] = (i < 4) ? 64'sd4096 : 64'sd0;
    end
    mphase = 0;
  endfunction

  function automatic void model_coef(input int a, input logic [15:0] d);
    if (a < int'(TAPS)) mh[a] = longint'($signed(d));
  endfunction

  function automatic logic model_accept(input logic [23:0] s);
    for (int k = int'(TAPS) - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0]  = longint'($signed(s));
    mphase = (mphase + 1) % 4;
    return (mphase == 0);
  endfunction

  function automatic void model_result(output logic [23:0] o, output logic sat);
    longint acc = 0;
    longint r;
    for (int i = 0; i < int'(TAPS); i++) acc += mx[i] * mh[i];
    r = (acc + 64'sd16384) >>> 15;
    if (r > 64'sd8388607) begin
      o = 24'h7FFFFF; sat = 1'b1;
    end else if (r < -64'sd8388608) begin
      o = 24'h800000; sat = 1'b1;
    end else begin
      o = 24'(r); sat = 1'b0;
    end
  endfunction

  function automatic void push_expect(input logic chk, input logic [23:0] c_out, input logic c_sat);
    exp_t e;
    model_result(e.e_out, e.e_sat);
    e.has_c = chk;
    e.c_out = c_out;
    e.c_sat = c_sat;
    sb.push_back(e);
  endfunction

  function automatic void add_vec(input logic [23:0] s, input logic chk, input logic [23:0] e, input logic es);
    vec_t v;
    v.sample = s; v.chk = chk; v.exp_out = e; v.exp_sat = es;
    vecs.push_back(v);
  endfunction

  // Output monitor: pops the scoreboard on each pulse, checks hold between pulses
  logic        prev_ov  = 1'b0;
  logic [23:0] last_out = '0;
  logic        last_sat = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov  = 1'b0;
      last_out = '0;
      last_sat = 1'b0;
    end else begin
      if (out_valid) begin
        n_out++;
        check("out_valid_adjacent", 32'(prev_ov), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_sample_model", 32'(out_sample), 32'(e.e_out));
          check("out_sat_model", 32'(out_sat), 32'(e.e_sat));
          if (e.has_c) begin
            check("out_sample_vector", 32'(out_sample), 32'(e.c_out));
            check("out_sat_vector", 32'(out_sat), 32'(e.c_sat));
          end
          last_out = e.e_out;
          last_sat = e.e_sat;
        end
      end else begin
        check("out_sample_hold", 32'(out_sample), 32'(last_out));
        check("out_sat_hold", 32'(out_sat), 32'(last_sat));
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    model_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sample", 32'(out_sample), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
  endtask

  // Offer one sample (optionally with a coefficient write on the accepting edge)
  task automatic drive(input logic [23:0] s, input logic chk, input logic [23:0] c_out,
                       input logic c_sat, input logic we, input int addr, input logic [15:0] d);
    int w = 0;
    in_valid = 1'b1; in_sample = s;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    coef_we = we; coef_addr = AW'(addr); coef_data = d;
    @(posedge clk);
    if (we) model_coef(addr, d);
    if (model_accept(s)) push_expect(chk, c_out, c_sat);
    #1;
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic write_coef(input int a, input logic [15:0] d, input logic lands);
    coef_we = 1'b1; coef_addr = AW'(a); coef_data = d;
    @(posedge clk);
    if (lands) model_coef(a, d);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    @(posedge clk); #1;
    while (sb.size() != 0 && w < 400) begin
      @(posedge clk); #1; w++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc_cnt;
    int          low_cnt;
    int          outs0;
    int          topup;
    logic        r;
    logic [23:0] s;

    // Impulse then DC vectors
    add_vec(24'h100000, 1'b0, 24'h0, 1'b0);
    add_vec(24'h000000, 1'b0, 24'h0, 1'b0);
    add_vec(24'h000000, 1'b0, 24'h0, 1'b0);
    add_vec(24'h000000, 1'b1, 24'h020000, 1'b0);
    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 3; j++) add_vec(24'h000000, 1'b0, 24'h0, 1'b0);
      add_vec(24'h000000, 1'b1, 24'h000000, 1'b0);
    end
    for (int g = 0; g < 6; g++) begin
      for (int j = 0; j < 3; j++) add_vec(24'h100000, 1'b0, 24'h0, 1'b0);
      add_vec(24'h100000, 1'b1, 24'h080000, 1'b0);
    end

    model_reset();
    do_reset(2);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sample, vecs[i].chk, vecs[i].exp_out, vecs[i].exp_sat, 1'b0, 0, 16'h0);
    end
    drain();

    // Saturation in both directions with full-scale coefficients
    for (int a = 0; a < int'(TAPS); a++) write_coef(a, 16'h7FFF, 1'b1);
    for (int i = 0; i < 16; i++) drive(24'h7FFFFF, i == 15, 24'h7FFFFF, 1'b1, 1'b0, 0, 16'h0);
    drain();
    for (int i = 0; i < 16; i++) drive(24'h800000, i == 15, 24'h800000, 1'b1, 1'b0, 0, 16'h0);
    drain();

    // Handshake with in_valid held high
    acc_cnt = 0; low_cnt = 0; topup = 0;
    outs0 = n_out;
    check("hs_start_phase", 32'(mphase), 32'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      check("hs_in_ready", 32'(in_ready), 32'(low_cnt == 0));
      check("hs_busy", 32'(busy), 32'(low_cnt != 0));
      s = 24'($urandom);
      in_sample = s;
      r = in_ready;
      @(posedge clk);
      if (r) begin
        acc_cnt++;
        if (model_accept(s)) begin
          push_expect(1'b0, 24'h0, 1'b0);
          low_cnt = 17;
        end
      end else if (low_cnt > 0) begin
        low_cnt--;
      end
      #1;
    end
    in_valid = 1'b0;
    while (mphase != 0) begin
      drive(24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
      topup++;
    end
    drain();
    check("hs_accept_vs_out", 32'((n_out - outs0) * 4), 32'(acc_cnt + topup));

    // Coefficient write during MAC is dropped; reset restores default coefs
    do_reset(1);
    for (int j = 0; j < 3; j++) drive(24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    drive(24'h100000, 1'b1, 24'h020000, 1'b0, 1'b0, 0, 16'h0);
    check("busy_in_mac", 32'(busy), 32'd1);
    write_coef(0, 16'h0000, 1'b0);
    for (int j = 0; j < 3; j++) drive(24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    drive(24'h100000, 1'b1, 24'h020000, 1'b0, 1'b0, 0, 16'h0);
    drain();

    // Coefficient write on the same edge as the 4th accept is used by that MAC
    for (int j = 0; j < 3; j++) drive(24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    drive(24'h100000, 1'b1, 24'h040000, 1'b0, 1'b1, 0, 16'h2000);
    drain();

    // Reset at MAC cycle 5 aborts the computation
    for (int j = 0; j < 4; j++) drive(24'h100000, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    repeat (5) @(posedge clk);
    #1;
    outs0 = n_out;
    do_reset(1);
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_out_valid", 32'(n_out - outs0), 32'd0);
    drive(24'h100000, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    for (int j = 0; j < 2; j++) drive(24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    drive(24'h0, 1'b1, 24'h020000, 1'b0, 1'b0, 0, 16'h0);
    drain();

    // Reset with a partial group restarts the phase count
    for (int j = 0; j < 2; j++) drive(24'h100000, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    do_reset(1);
    drive(24'h100000, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    for (int j = 0; j < 2; j++) drive(24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    drive(24'h0, 1'b1, 24'h020000, 1'b0, 1'b0, 0, 16'h0);
    drain();

    // Random coefficients and samples against the model
    for (int a = 0; a < int'(TAPS); a++) begin
      write_coef(a, 16'($urandom_range(0, 8191)) - 16'd4096, 1'b1);
    end
    for (int i = 0; i < 32; i++) drive(24'($urandom), 1'b0, 24'h0, 1'b0, 1'b0, 0, 16'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
